// File: rtl/avmm_write_coalescer_if.sv
// Avalon-MM bus bundle shared by the coalescer's slave (s0) and master (m0) ports.
interface avmm_write_coalescer_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
);
    // A request (write or read) is held stable until a cycle where waitrequest=0;
    // that cycle is the transfer. readdatavalid qualifies readdata on its own cycle.
    logic                  waitrequest;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  readdatavalid;
    logic [DATA_WIDTH-1:0] writedata;
    logic [ADDR_WIDTH-1:0] address;
    logic                  write;
    logic                  read;
    logic [BE_WIDTH-1:0]   byteenable;

    modport master (
        input  waitrequest, readdata, readdatavalid,
        output writedata, address, write, read, byteenable
    );

    modport slave (
        output waitrequest, readdata, readdatavalid,
        input  writedata, address, write, read, byteenable
    );
endinterface

// File: rtl/avmm_write_coalescer.sv
// Single-line Avalon-MM write combiner; reads drain the open line before passing through.
// Define WRITE_COMBINER_TIMEOUT_EN to flush an open line after TIMEOUT idle cycles.
module avmm_write_coalescer #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    avmm_write_coalescer_if.slave         s0,
    avmm_write_coalescer_if.master        m0,
    output logic [1:0]                    dbg_state_o
);
    localparam int OFS   = $clog2(BE_WIDTH);
    localparam int TAG_W = ADDR_WIDTH - OFS;

    if (TIMEOUT < 1 || DATA_WIDTH < 16 || BE_WIDTH * 8 != DATA_WIDTH) begin : g_bad_params
        $error("avmm_write_coalescer: invalid parameter set");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPEN  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [TAG_W-1:0]      tag_q, tag_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [BE_WIDTH-1:0]   mask_q, mask_d;

    logic [TAG_W-1:0]      s0_tag;
    logic [DATA_WIDTH-1:0] lane_bits;
    logic [BE_WIDTH-1:0]   merged_mask;
    logic                  hit;

    logic                  s0_wait;
    logic                  m0_wr, m0_rd;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [BE_WIDTH-1:0]   m0_be;
    logic [DATA_WIDTH-1:0] m0_wd;

    assign s0_tag      = s0.address[ADDR_WIDTH-1:OFS];
    assign hit         = (state_q == ST_OPEN) && (s0_tag == tag_q);
    assign merged_mask = mask_q | s0.byteenable;

    for (genvar g = 0; g < BE_WIDTH; g++) begin : g_lane
        assign lane_bits[g*8 +: 8] = {8{s0.byteenable[g]}};
    end

`ifdef WRITE_COMBINER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    // With TIMEOUT=1 the line would expire on its first idle cycle, so flush on load.
    localparam bit FLUSH_ON_LOAD = (TIMEOUT == 1);
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             timeout_hit;
    // Decided one cycle ahead so m0_write shows exactly TIMEOUT cycles after the last write.
    assign timeout_hit = (int'(timer_q) + 2) >= TIMEOUT;
`else
    localparam bit FLUSH_ON_LOAD = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        data_d  = data_q;
        mask_d  = mask_q;
        s0_wait = 1'b0;
        m0_wr   = 1'b0;
        m0_rd   = 1'b0;
        m0_addr = '0;
        m0_be   = '0;
        m0_wd   = '0;
`ifdef WRITE_COMBINER_TIMEOUT_EN
        timer_d = timer_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (s0.write) begin
                    tag_d   = s0_tag;
                    data_d  = s0.writedata & lane_bits;
                    mask_d  = s0.byteenable;
`ifdef WRITE_COMBINER_TIMEOUT_EN
                    timer_d = '0;
`endif
                    state_d = (&s0.byteenable || FLUSH_ON_LOAD) ? ST_FLUSH : ST_OPEN;
                end else if (s0.read) begin
                    m0_rd   = 1'b1;
                    m0_addr = s0.address;
                    s0_wait = m0.waitrequest;
                end
            end
            ST_OPEN: begin
                if (s0.write && hit) begin
                    data_d  = (data_q & ~lane_bits) | (s0.writedata & lane_bits);
                    mask_d  = merged_mask;
`ifdef WRITE_COMBINER_TIMEOUT_EN
                    timer_d = '0;
`endif
                    if (&merged_mask || FLUSH_ON_LOAD) state_d = ST_FLUSH;
                end else if (s0.write || s0.read) begin
                    // Miss or read: stall the slave until the line has drained.
                    s0_wait = 1'b1;
                    state_d = ST_FLUSH;
                end else begin
`ifdef WRITE_COMBINER_TIMEOUT_EN
                    timer_d = timer_q + TMR_W'(1);
                    if (timeout_hit) state_d = ST_FLUSH;
`endif
                end
            end
            ST_FLUSH: begin
                s0_wait = 1'b1;
                m0_wr   = 1'b1;
                m0_addr = {tag_q, {OFS{1'b0}}};
                m0_be   = mask_q;
                m0_wd   = data_q;
                if (!m0.waitrequest) begin
                    mask_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (reset) begin
            s0_wait = 1'b1;
            m0_wr   = 1'b0;
            m0_rd   = 1'b0;
            m0_addr = '0;
            m0_be   = '0;
            m0_wd   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tag_q   <= '0;
            data_q  <= '0;
            mask_q  <= '0;
`ifdef WRITE_COMBINER_TIMEOUT_EN
            timer_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
`ifdef WRITE_COMBINER_TIMEOUT_EN
            timer_q <= timer_d;
`endif
        end
    end

    assign s0.waitrequest   = s0_wait;
    assign s0.readdata      = m0.readdata;
    assign s0.readdatavalid = m0.readdatavalid;
    assign m0.write         = m0_wr;
    assign m0.read          = m0_rd;
    assign m0.address       = m0_addr;
    assign m0.byteenable    = m0_be;
    assign m0.writedata     = m0_wd;
    assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_avmm_write_coalescer.sv
// Bench for avmm_write_coalescer: directed scenarios plus random traffic against a line-merge model.
module tb_avmm_write_coalescer;
  localparam int DW  = 512;
  localparam int AW  = 64;
  localparam int BW  = DW / 8;
  localparam int TO  = 16;
  localparam int TXW = 1 + AW + BW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] dbg_state;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avmm_write_coalescer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BE_WIDTH(BW)) s0_bus ();
  avmm_write_coalescer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BE_WIDTH(BW)) m0_bus ();

  avmm_write_coalescer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BE_WIDTH(BW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .s0          (s0_bus),
    .m0          (m0_bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [TXW-1:0] got, input logic [TXW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // One open line kept as plain byte lanes; emits expected master transactions in order.
  logic [TXW-1:0] exp_q[$];
  logic           mdl_open = 1'b0;
  logic [AW-1:0]  mdl_base;
  logic [DW-1:0]  mdl_data;
  logic [BW-1:0]  mdl_be;

  task automatic model_flush();
    if (mdl_open) exp_q.push_back({1'b1, mdl_base, mdl_be, mdl_data});
    mdl_open = 1'b0;
  endtask

  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    logic [AW-1:0] base;
    base = (a / BW) * BW;
    if (mdl_open && base != mdl_base) model_flush();
    if (!mdl_open) begin
      mdl_open = 1'b1;
      mdl_base = base;
      mdl_data = '0;
      mdl_be   = '0;
    end
    for (int b = 0; b < BW; b++)
      if (be[b]) begin
        mdl_data[b*8 +: 8] = d[b*8 +: 8];
        mdl_be[b] = 1'b1;
      end
    if (mdl_be == {BW{1'b1}}) model_flush();
  endtask

  task automatic model_read(input logic [AW-1:0] a);
    model_flush();
    exp_q.push_back({1'b0, a, {BW{1'b0}}, {DW{1'b0}}});
  endtask

  // ---------------- master-side responder ----------------
  logic rand_mode = 1'b0;
  int   stall_left = 0;

  always @(posedge clk) begin
    #1;
    if (rand_mode) begin
      m0_bus.waitrequest   = ($urandom_range(0, 3) == 0);
      m0_bus.readdatavalid = $urandom_range(0, 1) == 1;
      for (int i = 0; i < DW / 32; i++) m0_bus.readdata[i*32 +: 32] = $urandom();
    end else begin
      m0_bus.readdatavalid = 1'b0;
      if (m0_bus.write && stall_left > 0) begin
        m0_bus.waitrequest = 1'b1;
        stall_left--;
      end else begin
        m0_bus.waitrequest = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  int             wr_hs = 0;
  int             wr_rise_cyc = -1;
  logic [AW-1:0]  last_wr_addr;
  logic [BW-1:0]  last_wr_be;
  logic [DW-1:0]  last_wr_data;
  logic           prev_wr = 1'b0;
  logic           prev_stall = 1'b0;
  logic [TXW-1:0] prev_out;
  logic [TXW-1:0] got_tx;

  always @(negedge clk) begin
    if (!reset) begin
      if (m0_bus.write && !prev_wr) wr_rise_cyc = cyc;
      prev_wr = m0_bus.write;
      got_tx = m0_bus.write ? {1'b1, m0_bus.address, m0_bus.byteenable, m0_bus.writedata}
                            : {1'b0, m0_bus.address, {BW{1'b0}}, {DW{1'b0}}};
      if (m0_bus.write && m0_bus.waitrequest) begin
        if (prev_stall) check("m0_stable_during_stall", got_tx, prev_out);
        prev_stall = 1'b1;
        prev_out = got_tx;
      end else begin
        prev_stall = 1'b0;
      end
      if ((m0_bus.write || m0_bus.read) && !m0_bus.waitrequest) begin
        if (m0_bus.write) begin
          wr_hs++;
          last_wr_addr = m0_bus.address;
          last_wr_be   = m0_bus.byteenable;
          last_wr_data = m0_bus.writedata;
        end
        check("m0_txn_expected", TXW'(exp_q.size() != 0), TXW'(1));
        if (exp_q.size() != 0) check("m0_txn", got_tx, exp_q.pop_front());
      end
      if (m0_bus.readdatavalid)
        check("s0_readdata_passthru", TXW'({s0_bus.readdatavalid, s0_bus.readdata}),
              TXW'({1'b1, m0_bus.readdata}));
    end else begin
      prev_wr = 1'b0;
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  int stalls = 0;
  int acc_cyc = 0;

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // All driver tasks start and end at posedge+1.
  task automatic drv_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    logic acc;
    model_write(a, d, be);
    s0_bus.address    = a;
    s0_bus.writedata  = d;
    s0_bus.byteenable = be;
    s0_bus.write      = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 500 && !acc; i++) begin
      @(negedge clk);
      if (!s0_bus.waitrequest) acc = 1'b1;
      else stalls++;
    end
    if (!acc) check("s0_write_accept_bound", TXW'(s0_bus.waitrequest), TXW'(0));
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    s0_bus.write = 1'b0;
  endtask

  task automatic drv_read(input logic [AW-1:0] a);
    logic acc;
    model_read(a);
    s0_bus.address = a;
    s0_bus.read    = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 500 && !acc; i++) begin
      @(negedge clk);
      if (!s0_bus.waitrequest) acc = 1'b1;
    end
    if (!acc) check("s0_read_accept_bound", TXW'(s0_bus.waitrequest), TXW'(0));
    @(posedge clk);
    #1;
    s0_bus.read = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    check(tag, TXW'(exp_q.size()), TXW'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] d1, d2;
    logic [BW-1:0] be;
    logic [AW-1:0] a;
    int wr0, r;

    s0_bus.write = 1'b0;
    s0_bus.read = 1'b1;
    s0_bus.address = 64'h1234;
    s0_bus.writedata = '0;
    s0_bus.byteenable = '0;
    m0_bus.waitrequest = 1'b0;
    m0_bus.readdata = '0;
    m0_bus.readdatavalid = 1'b0;

    // Reset outputs, with a read request held to show the outputs are forced.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s0_waitrequest", TXW'(s0_bus.waitrequest), TXW'(1));
    check("rst_m0_write", TXW'(m0_bus.write), TXW'(0));
    check("rst_m0_read", TXW'(m0_bus.read), TXW'(0));
    check("rst_m0_address", TXW'(m0_bus.address), TXW'(0));
    check("rst_m0_byteenable", TXW'(m0_bus.byteenable), TXW'(0));
    check("rst_m0_writedata", TXW'(m0_bus.writedata), TXW'(0));
    check("rst_state", TXW'(dbg_state), TXW'(0));
    s0_bus.read = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Two partial writes merge into one line, then a read drains it.
    d1 = rand_data();
    d2 = rand_data();
    wr0 = wr_hs;
    drv_write(64'h1000, d1, 64'h0F);
    drv_write(64'h1004, d2, 64'hF0);
    drv_read(64'h2000);
    wait_drain("t1_drain");
    check("t1_one_write", TXW'(wr_hs - wr0), TXW'(1));
    check("t1_addr", TXW'(last_wr_addr), TXW'(64'h1000));
    check("t1_be", TXW'(last_wr_be), TXW'(64'hFF));
    check("t1_merge", TXW'(last_wr_data), TXW'({d2[63:32], d1[31:0]}));

    // Sixteen back-to-back word writes fill a line with no stalls.
    stalls = 0;
    for (int i = 0; i < 16; i++)
      drv_write(64'h40 + 64'(4 * i), rand_data(), 64'hF << (4 * i));
    wait_drain("t2_drain");
    check("t2_stalls", TXW'(stalls), TXW'(0));
    check("t2_flush_cycle", TXW'(wr_rise_cyc), TXW'(acc_cyc + 1));
    check("t2_be_full", TXW'(last_wr_be), TXW'({BW{1'b1}}));
    check("t2_addr", TXW'(last_wr_addr), TXW'(64'h40));

    // Miss with the master stalled for three cycles.
    drv_write(64'h1000, rand_data(), 64'h0F);
    stall_left = 3;
    stalls = 0;
    drv_write(64'h2000, rand_data(), 64'h0F);
    wait_drain("t3_drain");
    check("t3_s0_stall_cycles", TXW'(stalls), TXW'(5));
    check("t3_first_flush_addr", TXW'(last_wr_addr), TXW'(64'h1000));
    check("t3_line_open", TXW'(dbg_state), TXW'(1));
    drv_read(64'h2040);
    wait_drain("t3_read_drain");

    // Idle behaviour of an open line.
    wr0 = wr_hs;
    drv_write(64'h5000, rand_data(), 64'h3);
    r = acc_cyc;
`ifdef WRITE_COMBINER_TIMEOUT_EN
    model_flush();
    wait_drain("t4_timeout_drain");
    check("t4_timeout_cycle", TXW'(wr_rise_cyc), TXW'(r + TO));
`else
    repeat (200) @(negedge clk);
    check("t4_no_timeout_write", TXW'(wr_hs - wr0), TXW'(0));
    check("t4_still_open", TXW'(dbg_state), TXW'(1));
    @(posedge clk);
    #1;
    drv_read(64'h5040);
    wait_drain("t4_read_drain");
`endif

    // Overlapping byte-0 writes: later value wins.
    d1 = rand_data();
    d1[7:0] = 8'hAA;
    d2 = rand_data();
    d2[7:0] = 8'h55;
    drv_write(64'h3000, d1, 64'h1);
    drv_write(64'h3000, d2, 64'h1);
    drv_read(64'h3040);
    wait_drain("t5_drain");
    check("t5_byte0", TXW'(last_wr_data[7:0]), TXW'(8'h55));
    check("t5_be", TXW'(last_wr_be), TXW'(64'h1));

    // Reset while flushing drops the line.
    drv_write(64'h6000, rand_data(), 64'h3);
    stall_left = 1000;
    model_read(64'h7000);
    s0_bus.address = 64'h7000;
    s0_bus.read = 1'b1;
    for (int i = 0; i < 20 && !m0_bus.write; i++) @(negedge clk);
    check("t6_reached_flush", TXW'(m0_bus.write), TXW'(1));
    reset = 1'b1;
    #1;
    check("t6_m0_write_async_drop", TXW'(m0_bus.write), TXW'(0));
    check("t6_s0_wait_in_reset", TXW'(s0_bus.waitrequest), TXW'(1));
    s0_bus.read = 1'b0;
    stall_left = 0;
    exp_q.delete();
    mdl_open = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("t6_idle_after_reset", TXW'(dbg_state), TXW'(0));
    drv_write(64'h6000, rand_data(), 64'h30);
    drv_read(64'h7000);
    wait_drain("t6_drain");
    check("t6_fresh_mask", TXW'(last_wr_be), TXW'(64'h30));

    // Random traffic over a few lines with random master stalls.
    rand_mode = 1'b1;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      a = 64'($urandom_range(0, 3) * BW + $urandom_range(0, BW - 1));
      if (r < 2) begin
        drv_read(a);
      end else begin
        case ($urandom_range(0, 3))
          0: be = {BW{1'b1}};
          1: be = BW'(64'h1) << $urandom_range(0, BW - 1);
          default: begin
            be = '0;
            for (int k = 0; k < BW / 32; k++) be[k*32 +: 32] = $urandom();
          end
        endcase
        drv_write(a, rand_data(), be);
      end
    end
    drv_read(64'h8000);
    wait_drain("rand_drain");
    rand_mode = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
